// File: rtl/event_capture.sv
// event_capture: armed, single-shot transient recorder on a sample stream.
//
// Once armed it keeps a circular pre-trigger history in a local RAM. When a
// valid sample exceeds trigger_level it records a post-trigger window. The
// record (pre history, trigger sample, post samples) is then replayed as one
// AXI-Stream packet with tlast on its final word. After that it returns to
// IDLE and must be armed again.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   s_axis_tvalid/tdata      input samples (no tready, the source cannot stall)
//   trigger_level            unsigned threshold, compared every cycle
//   arm                      start pulse, honoured only in IDLE
//   cfg_pre_len/post_len     record geometry, latched on arm
//   m_axis_tvalid/tready/
//   tdata/tlast              output record stream
//   busy, state              status (state: IDLE=0 .. READOUT=4)
//   event_count              completed records, wraps modulo 2^32
module event_capture #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [DATA_WIDTH-1:0] trigger_level,
  input  logic                  arm,
  input  logic [ADDR_WIDTH-1:0] cfg_pre_len,
  input  logic [ADDR_WIDTH-1:0] cfg_post_len,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  busy,
  output logic [2:0]            state,
  output logic [31:0]           event_count
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] ONE_A   = 1;
  localparam logic [ADDR_WIDTH:0]   ONE_W   = 1;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PREFILL   = 3'd1,
    S_WAIT_TRIG = 3'd2,
    S_POST      = 3'd3,
    S_READOUT   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pre_q, pre_d;
  logic [ADDR_WIDTH:0]   post_eff_q, post_eff_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] fill_q, fill_d;
  logic [ADDR_WIDTH:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0] start_addr_q, start_addr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   rd_left_q, rd_left_d;   // reads still to issue
  logic                  rd_pend_q, rd_pend_d;   // RAM output valid this cycle
  logic                  rd_last_q, rd_last_d;   // pending read is the final word
  logic                  out_vld_q, out_vld_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_last_q, out_last_d;
  logic                  sk_vld_q, sk_vld_d;     // skid slot behind the output reg
  logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
  logic                  sk_last_q, sk_last_d;
  logic [31:0]           event_count_q, event_count_d;

  logic                  wr_en, rd_en, pop, go_readout;
  logic [ADDR_WIDTH-1:0] go_start;
  logic [1:0]            occ, occ_after;
  logic [ADDR_WIDTH:0]   post_req, room, post_eff_cfg;

  // Capture buffer: simple dual-port RAM with a registered read port.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_ptr_q] <= s_axis_tdata;
    if (rd_en) mem_rdata     <= mem[rd_ptr_q];
  end

  // Post length is at least one (the trigger sample) and is clipped so the
  // whole record fits in the buffer without overwriting its oldest word.
  always_comb begin
    post_req     = (cfg_post_len == '0) ? ONE_W : {1'b0, cfg_post_len};
    room         = DEPTH_W - {1'b0, cfg_pre_len};
    post_eff_cfg = (post_req < room) ? post_req : room;
  end

  always_comb begin
    state_d       = state_q;
    pre_d         = pre_q;
    post_eff_d    = post_eff_q;
    wr_ptr_d      = wr_ptr_q;
    fill_d        = fill_q;
    post_cnt_d    = post_cnt_q;
    start_addr_d  = start_addr_q;
    rd_ptr_d      = rd_ptr_q;
    rd_left_d     = rd_left_q;
    rd_pend_d     = rd_pend_q;
    rd_last_d     = rd_last_q;
    out_vld_d     = out_vld_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    sk_vld_d      = sk_vld_q;
    sk_data_d     = sk_data_q;
    sk_last_d     = sk_last_q;
    event_count_d = event_count_q;
    wr_en         = 1'b0;
    rd_en         = 1'b0;
    go_readout    = 1'b0;
    go_start      = start_addr_q;
    pop           = out_vld_q & m_axis_tready;
    occ           = {1'b0, out_vld_q} + {1'b0, sk_vld_q} + {1'b0, rd_pend_q};
    occ_after     = occ - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (arm) begin
          pre_d      = cfg_pre_len;
          post_eff_d = post_eff_cfg;
          wr_ptr_d   = '0;
          fill_d     = '0;
          post_cnt_d = '0;
          state_d    = (cfg_pre_len == '0) ? S_WAIT_TRIG : S_PREFILL;
        end
      end

      S_PREFILL: begin
        if (s_axis_tvalid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
          fill_d   = fill_q + ONE_A;
          if (fill_q + ONE_A == pre_q) state_d = S_WAIT_TRIG;
        end
      end

      S_WAIT_TRIG: begin
        if (s_axis_tvalid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + ONE_A;
          if (s_axis_tdata > trigger_level) begin
            // Oldest record word sits pre slots behind the trigger write.
            go_start     = wr_ptr_q - pre_q;
            start_addr_d = go_start;
            post_cnt_d   = ONE_W;
            if (post_eff_q == ONE_W) go_readout = 1'b1;
            else                     state_d    = S_POST;
          end
        end
      end

      S_POST: begin
        if (s_axis_tvalid) begin
          wr_en      = 1'b1;
          wr_ptr_d   = wr_ptr_q + ONE_A;
          post_cnt_d = post_cnt_q + ONE_W;
          if (post_cnt_q + ONE_W == post_eff_q) go_readout = 1'b1;
        end
      end

      S_READOUT: begin
        // Issue a read only if its data is guaranteed a slot (output reg or
        // skid) when it lands; this keeps the stream gap-free at full rate.
        rd_pend_d = 1'b0;
        rd_last_d = 1'b0;
        if (rd_left_q != '0 && occ_after < 2'd2) begin
          rd_en     = 1'b1;
          rd_ptr_d  = rd_ptr_q + ONE_A;
          rd_left_d = rd_left_q - ONE_W;
          rd_pend_d = 1'b1;
          rd_last_d = (rd_left_q == ONE_W);
        end

        if (!out_vld_q || pop) begin
          if (sk_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = sk_data_q;
            out_last_d = sk_last_q;
            sk_vld_d   = rd_pend_q;
            sk_data_d  = mem_rdata;
            sk_last_d  = rd_last_q;
          end else if (rd_pend_q) begin
            out_vld_d  = 1'b1;
            out_data_d = mem_rdata;
            out_last_d = rd_last_q;
          end else begin
            out_vld_d  = 1'b0;
            out_last_d = 1'b0;
          end
        end else if (rd_pend_q) begin
          sk_vld_d  = 1'b1;
          sk_data_d = mem_rdata;
          sk_last_d = rd_last_q;
        end

        if (pop && out_last_q) begin
          state_d       = S_IDLE;
          event_count_d = event_count_q + 32'd1;
          out_vld_d     = 1'b0;
          out_last_d    = 1'b0;
          sk_vld_d      = 1'b0;
          rd_pend_d     = 1'b0;
          rd_last_d     = 1'b0;
          rd_left_d     = '0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (go_readout) begin
      state_d   = S_READOUT;
      rd_ptr_d  = go_start;
      rd_left_d = {1'b0, pre_q} + post_eff_q;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= S_IDLE;
      pre_q         <= '0;
      post_eff_q    <= '0;
      wr_ptr_q      <= '0;
      fill_q        <= '0;
      post_cnt_q    <= '0;
      start_addr_q  <= '0;
      rd_ptr_q      <= '0;
      rd_left_q     <= '0;
      rd_pend_q     <= 1'b0;
      rd_last_q     <= 1'b0;
      out_vld_q     <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      sk_vld_q      <= 1'b0;
      sk_data_q     <= '0;
      sk_last_q     <= 1'b0;
      event_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pre_q         <= pre_d;
      post_eff_q    <= post_eff_d;
      wr_ptr_q      <= wr_ptr_d;
      fill_q        <= fill_d;
      post_cnt_q    <= post_cnt_d;
      start_addr_q  <= start_addr_d;
      rd_ptr_q      <= rd_ptr_d;
      rd_left_q     <= rd_left_d;
      rd_pend_q     <= rd_pend_d;
      rd_last_q     <= rd_last_d;
      out_vld_q     <= out_vld_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      sk_vld_q      <= sk_vld_d;
      sk_data_q     <= sk_data_d;
      sk_last_q     <= sk_last_d;
      event_count_q <= event_count_d;
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tlast  = out_last_q;
  assign busy          = (state_q != S_IDLE);
  assign state         = state_q;
  assign event_count   = event_count_q;

endmodule

// File: tb/tb_event_capture.sv
// Bench for event_capture (ADDR_WIDTH=4, 16-deep buffer). Inputs are driven
// and outputs sampled on the falling edge. The reference model keeps every
// valid sample driven after arm and derives the expected record directly:
// first sample at index >= pre above the level is the trigger; the record is
// the pre samples before it, the trigger, and post_eff-1 samples after it.
module tb_event_capture;
  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          s_axis_tvalid = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic [DW-1:0] trigger_level = '0;
  logic          arm = 1'b0;
  logic [AW-1:0] cfg_pre_len = '0;
  logic [AW-1:0] cfg_post_len = '0;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tlast;
  logic          busy;
  logic [2:0]    state;
  logic [31:0]   event_count;

  always #5 aclk = ~aclk;

  event_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata),
    .trigger_level(trigger_level), .arm(arm),
    .cfg_pre_len(cfg_pre_len), .cfg_post_len(cfg_post_len),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .busy(busy), .state(state), .event_count(event_count)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int ramp_v = 0;
  int ev_exp = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge aclk);
    aresetn = 1'b0; arm = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    ev_exp = 0;
    @(negedge aclk);
  endtask

  // One complete record. use_ramp=0 gives random data plus stray arm pulses
  // and config changes while busy, all of which must be ignored.
  task automatic run_record(input string nm, input int pre, input int post, input int lvl,
                            input bit use_ramp, input int gmode, input int rpct,
                            input int exp_first, input int exp_n);
    logic [DW-1:0] sq[$];
    logic [DW-1:0] gd[$];
    bit            gl[$];
    bit            done, stalled, st_l, covered;
    logic [DW-1:0] st_d;
    int            k, pe, n, gcnt;
    @(negedge aclk);
    cfg_pre_len   = pre[AW-1:0];
    cfg_post_len  = post[AW-1:0];
    trigger_level = lvl[DW-1:0];
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b0;
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
    done = 0; stalled = 0; gcnt = 0; st_l = 0; st_d = '0;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (stalled) begin
        chk({nm, " hold vld"},  m_axis_tvalid, 1);
        chk({nm, " hold data"}, m_axis_tdata, st_d);
        chk({nm, " hold last"}, m_axis_tlast, st_l);
      end
      m_axis_tready = ($urandom_range(0, 99) < rpct);
      case (gmode)
        0:       s_axis_tvalid = 1'b1;
        1:       s_axis_tvalid = (gcnt % 3 == 0);
        default: s_axis_tvalid = $urandom_range(0, 1) == 1;
      endcase
      gcnt++;
      if (s_axis_tvalid) begin
        if (use_ramp) begin
          s_axis_tdata = ramp_v[DW-1:0];
          ramp_v++;
        end else begin
          s_axis_tdata = DW'($urandom_range(0, 65535));
        end
        sq.push_back(s_axis_tdata);
      end
      if (!use_ramp) begin
        arm          = ($urandom_range(0, 7) == 0);
        cfg_pre_len  = AW'($urandom);
        cfg_post_len = AW'($urandom);
      end
      if (m_axis_tvalid) begin
        if (m_axis_tready) begin
          gd.push_back(m_axis_tdata);
          gl.push_back(m_axis_tlast);
          stalled = 0;
          if (m_axis_tlast) done = 1;
        end else begin
          stalled = 1;
          st_d = m_axis_tdata;
          st_l = m_axis_tlast;
        end
      end else begin
        stalled = 0;
      end
      @(negedge aclk);
    end
    arm = 1'b0; s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;

    pe = (post < 1) ? 1 : post;
    if (pe > DEPTH - pre) pe = DEPTH - pre;
    n = pre + pe;
    k = -1;
    for (int i = pre; i < sq.size(); i++) begin
      if (sq[i] > lvl[DW-1:0]) begin
        k = i;
        break;
      end
    end
    covered = (k >= 0) && (k + pe <= sq.size());
    chk({nm, " done"}, done, 1);
    chk({nm, " stim covers record"}, covered, 1);
    chk({nm, " length"}, gd.size(), n);
    if (exp_n > 0) chk({nm, " length vs plan"}, gd.size(), exp_n);
    if (exp_first >= 0 && gd.size() > 0) chk({nm, " first word"}, gd[0], exp_first);
    if (covered) begin
      for (int i = 0; i < n && i < gd.size(); i++) begin
        chk($sformatf("%s word%0d", nm, i), gd[i], sq[k - pre + i]);
        chk($sformatf("%s last%0d", nm, i), gl[i], (i == n - 1));
      end
    end
    if (done) ev_exp++;
    chk({nm, " vld after"},  m_axis_tvalid, 0);
    chk({nm, " state after"}, state, 0);
    chk({nm, " busy after"},  busy, 0);
    chk({nm, " event_count"}, event_count, ev_exp);
  endtask

  initial begin
    bit hit;
    // Reset values
    @(negedge aclk);
    chk("rst state", state, 0);
    chk("rst busy", busy, 0);
    chk("rst vld", m_axis_tvalid, 0);
    chk("rst last", m_axis_tlast, 0);
    chk("rst data", m_axis_tdata, 0);
    chk("rst evcnt", event_count, 0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Reset in the middle of a readout held off by tready=0
    ramp_v = 0;
    cfg_pre_len = 4; cfg_post_len = 4; trigger_level = 100;
    arm = 1'b1;
    @(negedge aclk);
    arm = 1'b0;
    hit = 0;
    for (int cyc = 0; cyc < 300 && !hit; cyc++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = ramp_v[DW-1:0];
      ramp_v++;
      @(negedge aclk);
      hit = (state == 3'd4) && m_axis_tvalid;
    end
    chk("midrst reached readout", hit, 1);
    s_axis_tvalid = 1'b0;
    aresetn = 1'b0;
    #1;
    chk("midrst async vld", m_axis_tvalid, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    chk("midrst state", state, 0);
    chk("midrst busy", busy, 0);
    chk("midrst vld", m_axis_tvalid, 0);
    chk("midrst last", m_axis_tlast, 0);
    chk("midrst evcnt", event_count, 0);
    ev_exp = 0;

    // Directed records from the plan
    ramp_v = 0; run_record("basic",   4, 4, 100, 1, 0, 100, 97, 8);
    ramp_v = 0; run_record("bkpr",    4, 4, 100, 1, 0, 50,  97, 8);
    ramp_v = 0; run_record("minrec",  0, 0, 9,   1, 0, 100, 10, 1);
    ramp_v = 0; run_record("preign",  8, 1, 5,   1, 0, 100, 0,  9);
    do_reset();
    ramp_v = 0; run_record("wrap",    10, 6, 40,  1, 0, 100, 31,  16);
    run_record("rearm",               10, 6, 200, 1, 0, 100, 191, 16);
    chk("rearm evcnt two", event_count, 2);
    ramp_v = 0; run_record("gapped",  10, 6, 40,  1, 1, 70,  31,  16);

    // Randomized records
    for (int r = 0; r < 25; r++) begin
      run_record($sformatf("rnd%0d", r), int'($urandom_range(0, DEPTH - 1)),
                 int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 60000)),
                 0, int'($urandom_range(0, 2)), int'($urandom_range(30, 100)), -1, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/event_capture.md
Name: event_capture

Overview:
- Sits directly downstream of the ADC front-end and consumes its 16-bit sample stream (sum of channel magnitudes).
- Once armed, it keeps a circular pre-trigger history. On a threshold crossing it captures a configurable post-trigger window.
- It then replays the whole record as a framed AXI-Stream packet (tlast on the final word) to the DMA/readout path.
- Single-shot: it returns to idle after each record and must be re-armed.

Parameters:
- DATA_WIDTH, 16, sample width on input and output streams.
- ADDR_WIDTH, 10, log2 of capture buffer depth (buffer = 2^ADDR_WIDTH words).

Ports:
- aclk  in  1  clock
- aresetn  in  1  reset
- s_axis_tvalid  in  1  input sample valid; no tready, source cannot stall
- s_axis_tdata  in  DATA_WIDTH  input sample, unsigned
- trigger_level  in  DATA_WIDTH  unsigned threshold, used live every cycle
- arm  in  1  single-cycle start pulse
- cfg_pre_len  in  ADDR_WIDTH  pre-trigger sample count
- cfg_post_len  in  ADDR_WIDTH  post-trigger sample count, trigger sample included
- m_axis_tvalid  out  1  output valid
- m_axis_tready  in  1  output ready
- m_axis_tdata  out  DATA_WIDTH  output sample
- m_axis_tlast  out  1  last word of record
- busy  out  1  high whenever state is not IDLE
- state  out  3  current state encoding
- event_count  out  32  completed records, wraps modulo 2^32

Behaviour:
- Clock and reset: clock aclk; reset aresetn, asynchronous, active-low.
- Reset values: state=IDLE(0), busy=0, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, event_count=0, all pointers and counters 0.
- Reset mid-operation: record discarded, no tlast emitted, buffer contents don't-care.
- Buffer: inferred simple dual-port RAM, 2^ADDR_WIDTH x DATA_WIDTH, one registered read port.
- Write rule: a sample is written only on s_axis_tvalid=1 in PREFILL, WAIT_TRIG or POST. wr_ptr increments per write and wraps at 2^ADDR_WIDTH. Cycles with tvalid=0 change nothing.
- State encoding: IDLE=0, PREFILL=1, WAIT_TRIG=2, POST=3, READOUT=4.
- IDLE:
  - arm=1 latches pre=cfg_pre_len and post_eff = min(max(cfg_post_len,1), 2^ADDR_WIDTH - pre); clears wr_ptr and fill counter.
  - Goes to PREFILL, or straight to WAIT_TRIG if pre=0.
  - arm in any other state is ignored.
- PREFILL:
  - Writes samples; fill counter counts writes.
  - After the write of sample number pre, goes to WAIT_TRIG.
  - No trigger is evaluated in this state.
- WAIT_TRIG:
  - Keeps writing circularly.
  - Trigger condition: a valid sample with s_axis_tdata > trigger_level (strict, unsigned).
  - The trigger sample is written.
  - start_addr = (trigger write address - pre) mod 2^ADDR_WIDTH.
  - post counter = 1.
  - If post_eff=1, goes directly to READOUT; else goes to POST.
- POST:
  - Writes samples and increments the post counter.
  - When the counter reaches post_eff (on that write), goes to READOUT.
  - Samples arriving after that are dropped.
- READOUT:
  - rd_ptr = start_addr; words = pre + post_eff.
  - Input is ignored.
  - First m_axis_tvalid asserts no later than 2 cycles after entering READOUT.
  - Standard AXI-S handshake: while tvalid=1 and tready=0, tdata and tlast are held stable. No bubbles are required when tready stays high; a prefetch/skid register is allowed.
  - m_axis_tlast=1 only on word pre+post_eff.
  - On that word's handshake: tvalid drops next cycle, event_count increments, state goes to IDLE.
  - An arm on the same cycle as the final handshake is ignored.
- Output order: oldest pre sample first, the trigger sample at position pre+1, then post samples in arrival order.

Test Plan:
1. Reset check: assert aresetn=0 mid-READOUT, release -> state=0, busy=0, m_axis_tvalid=0, event_count=0; no tlast seen.
2. Basic capture:
   - Setup: ADDR_WIDTH=10, pre=4, post=4, trigger_level=100, s_axis_tdata ramp 0,1,2,... every cycle, arm before sample 0.
   - Required: packet 97,98,99,100,101,102,103,104; tlast on 104; event_count=1; state returns to 0.
3. Backpressure: same as 2 with m_axis_tready random 50% -> identical 8-word sequence, no loss or duplication, tdata and tlast stable while stalled.
4. Minimum record: pre=0, post=0, trigger_level=9, ramp -> single word 10 with tlast=1; busy deasserts afterwards.
5. Trigger ignored in PREFILL:
   - Setup: pre=8, post=1, trigger_level=5, ramp from 0.
   - Required: values 6,7 do not trigger; trigger fires on sample 8; packet 0..8 (9 words), tlast on 8.
6. Wrap-around and re-arm:
   - Setup: ADDR_WIDTH=4, pre=10, post=6, trigger_level=40, ramp from 0.
   - Required: packet 31..46 contiguous, tlast on 46.
   - Then arm again with trigger_level=200 and the ramp continuing -> second packet 191..206, event_count=2.
   - Gapped s_axis_tvalid (1-in-3 valid) gives the same packet contents.
